ibex_ex_issue: RTL and testbench

Issue-side sequencer that drives the execute block from the decode side. It accepts one decoded ALU/multiply/divide operation per handshake and presents it to the execute block. It holds the two 34-bit intermediate-value registers that multi-cycle operations write back through `imd_val_we`/`imd_val_d`, waits for `ex_valid`, then offers the result to writeback over a valid/ready handshake.

---
 rtl/ibex_ex_issue_if.sv | 27 ++
 rtl/ibex_ex_issue.sv | 160 ++++++++++++++++
 tb/tb_ibex_ex_issue.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_ex_issue_if.sv
// Issue-side handshake between decode and ibex_ex_issue.
// Carries one decoded ALU/multdiv operation per valid/ready handshake.
//   master: decode side, drives the operation fields and instr_valid_i
//   slave : issue sequencer, drives instr_ready_o
interface ibex_ex_issue_if;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [5:0]  op_alu_operator_i;
    logic [1:0]  op_md_operator_i;
    logic [1:0]  op_md_signed_i;
    logic        op_is_mult_i;
    logic        op_is_div_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;

    modport master (
        output instr_valid_i, op_alu_operator_i, op_md_operator_i, op_md_signed_i,
               op_is_mult_i, op_is_div_i, op_a_i, op_b_i,
        input  instr_ready_o
    );

    modport slave (
        input  instr_valid_i, op_alu_operator_i, op_md_operator_i, op_md_signed_i,
               op_is_mult_i, op_is_div_i, op_a_i, op_b_i,
        output instr_ready_o
    );
endinterface

// File: rtl/ibex_ex_issue.sv
// ibex_ex_issue: issue-side sequencer for the execute block.
// Accepts one operation (instr interface), drives it into the execute block
// while holding the two 34-bit intermediate registers that multi-cycle
// operations write back, captures the result on ex_valid_i and offers it to
// writeback over result_valid_o/result_ready_i.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   instr               slave side of the issue handshake
//   kill_i              flush, aborts anything in flight
//   alu_*/multdiv_*     operands and controls to the execute block
//   mult/div_en/sel     unit enables, only asserted while executing
//   imd_val_*           intermediate register write port / contents
//   ex_valid_i          execute result valid, result_ex_i its data
//   result_*/illegal_o  writeback handshake and registered result
module ibex_ex_issue #(
    parameter int RV32M = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ibex_ex_issue_if.slave      instr,
    input  logic                kill_i,
    output logic [5:0]          alu_operator_o,
    output logic [31:0]         alu_operand_a_o,
    output logic [31:0]         alu_operand_b_o,
    output logic                alu_instr_first_cycle_o,
    output logic [1:0]          multdiv_operator_o,
    output logic [1:0]          multdiv_signed_mode_o,
    output logic [31:0]         multdiv_operand_a_o,
    output logic [31:0]         multdiv_operand_b_o,
    output logic                mult_en_o,
    output logic                div_en_o,
    output logic                mult_sel_o,
    output logic                div_sel_o,
    output logic                multdiv_ready_id_o,
    input  logic [1:0]          imd_val_we_i,
    input  logic [67:0]         imd_val_d_i,
    output logic [67:0]         imd_val_q_o,
    input  logic                ex_valid_i,
    input  logic [31:0]         result_ex_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [31:0]         result_o,
    output logic                illegal_o
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    localparam logic NO_MD = (RV32M == 0);

    state_e            state;
    logic [5:0]        alu_op_q;
    logic [1:0]        md_op_q;
    logic [1:0]        md_signed_q;
    logic [31:0]       op_a_q;
    logic [31:0]       op_b_q;
    logic              first_q;
    logic              mult_q;
    logic              div_q;
    logic              md_ready_q;
    logic              res_valid_q;
    logic [31:0]       result_q;
    logic              illegal_q;
    logic [1:0][33:0]  imd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            alu_op_q    <= '0;
            md_op_q     <= '0;
            md_signed_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            first_q     <= 1'b0;
            mult_q      <= 1'b0;
            div_q       <= 1'b0;
            md_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            imd_q       <= '0;
        end else if (kill_i) begin
            // Flush wins over accept, imd writes and result capture.
            state       <= IDLE;
            first_q     <= 1'b0;
            mult_q      <= 1'b0;
            div_q       <= 1'b0;
            md_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr.instr_valid_i) begin
                        alu_op_q    <= instr.op_alu_operator_i;
                        md_op_q     <= instr.op_md_operator_i;
                        md_signed_q <= instr.op_md_signed_i;
                        op_a_q      <= instr.op_a_i;
                        op_b_q      <= instr.op_b_i;
                        if (NO_MD && (instr.op_is_mult_i || instr.op_is_div_i)) begin
                            // No multdiv unit: answer immediately, never enter EXEC.
                            state       <= DONE;
                            result_q    <= '0;
                            illegal_q   <= 1'b1;
                            res_valid_q <= 1'b1;
                        end else begin
                            // Control outputs are registered, so they are
                            // set up here for the first EXEC cycle.
                            state      <= EXEC;
                            illegal_q  <= 1'b0;
                            first_q    <= 1'b1;
                            mult_q     <= instr.op_is_mult_i;
                            div_q      <= instr.op_is_div_i;
                            md_ready_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    first_q <= 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        if (imd_val_we_i[i]) imd_q[i] <= imd_val_d_i[34*i +: 34];
                    end
                    if (ex_valid_i) begin
                        state       <= DONE;
                        result_q    <= result_ex_i;
                        res_valid_q <= 1'b1;
                        mult_q      <= 1'b0;
                        div_q       <= 1'b0;
                        md_ready_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign instr.instr_ready_o     = (state == IDLE);
    assign alu_operator_o          = alu_op_q;
    assign alu_operand_a_o         = op_a_q;
    assign alu_operand_b_o         = op_b_q;
    assign alu_instr_first_cycle_o = first_q;
    assign multdiv_operator_o      = md_op_q;
    assign multdiv_signed_mode_o   = md_signed_q;
    assign multdiv_operand_a_o     = op_a_q;
    assign multdiv_operand_b_o     = op_b_q;
    assign mult_en_o               = mult_q;
    assign mult_sel_o              = mult_q;
    assign div_en_o                = div_q;
    assign div_sel_o               = div_q;
    assign multdiv_ready_id_o      = md_ready_q;
    assign imd_val_q_o             = imd_q;
    assign result_valid_o          = res_valid_q;
    assign result_o                = result_q;
    assign illegal_o               = illegal_q;

endmodule

// File: tb/tb_ibex_ex_issue.sv
// Directed bench for ibex_ex_issue: a full-featured instance (RV32M=2) and a
// no-multdiv instance (RV32M=0) share all inputs.
module tb_ibex_ex_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic [1:0]  imd_we;
    logic [67:0] imd_d;
    logic        ex_valid;
    logic [31:0] result_ex;
    logic        result_ready;

    ibex_ex_issue_if if0 ();
    ibex_ex_issue_if if1 ();

    assign if1.instr_valid_i     = if0.instr_valid_i;
    assign if1.op_alu_operator_i = if0.op_alu_operator_i;
    assign if1.op_md_operator_i  = if0.op_md_operator_i;
    assign if1.op_md_signed_i    = if0.op_md_signed_i;
    assign if1.op_is_mult_i      = if0.op_is_mult_i;
    assign if1.op_is_div_i       = if0.op_is_div_i;
    assign if1.op_a_i            = if0.op_a_i;
    assign if1.op_b_i            = if0.op_b_i;

    logic [5:0]  alu_op,  d1_alu_op;
    logic [31:0] alu_a,   d1_alu_a, alu_b, d1_alu_b;
    logic        first,   d1_first;
    logic [1:0]  md_op,   d1_md_op, md_sg, d1_md_sg;
    logic [31:0] md_a,    d1_md_a,  md_b,  d1_md_b;
    logic        mult_en, d1_mult_en, div_en, d1_div_en;
    logic        mult_sel, d1_mult_sel, div_sel, d1_div_sel;
    logic        md_rdy,  d1_md_rdy;
    logic [67:0] imd_q,   d1_imd_q;
    logic        res_vld, d1_res_vld;
    logic [31:0] res,     d1_res;
    logic        ill,     d1_ill;

    ibex_ex_issue #(.RV32M(2)) dut (
        .clk_i(clk), .rst_i(rst), .instr(if0.slave), .kill_i(kill),
        .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
        .alu_instr_first_cycle_o(first),
        .multdiv_operator_o(md_op), .multdiv_signed_mode_o(md_sg),
        .multdiv_operand_a_o(md_a), .multdiv_operand_b_o(md_b),
        .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
        .multdiv_ready_id_o(md_rdy),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(imd_q),
        .ex_valid_i(ex_valid), .result_ex_i(result_ex),
        .result_valid_o(res_vld), .result_ready_i(result_ready),
        .result_o(res), .illegal_o(ill)
    );

    ibex_ex_issue #(.RV32M(0)) dut_nomd (
        .clk_i(clk), .rst_i(rst), .instr(if1.slave), .kill_i(kill),
        .alu_operator_o(d1_alu_op), .alu_operand_a_o(d1_alu_a), .alu_operand_b_o(d1_alu_b),
        .alu_instr_first_cycle_o(d1_first),
        .multdiv_operator_o(d1_md_op), .multdiv_signed_mode_o(d1_md_sg),
        .multdiv_operand_a_o(d1_md_a), .multdiv_operand_b_o(d1_md_b),
        .mult_en_o(d1_mult_en), .div_en_o(d1_div_en), .mult_sel_o(d1_mult_sel), .div_sel_o(d1_div_sel),
        .multdiv_ready_id_o(d1_md_rdy),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(d1_imd_q),
        .ex_valid_i(ex_valid), .result_ex_i(result_ex),
        .result_valid_o(d1_res_vld), .result_ready_i(result_ready),
        .result_o(d1_res), .illegal_o(d1_ill)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [5:0] aop, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b);
        if0.instr_valid_i     = v;
        if0.op_alu_operator_i = aop;
        if0.op_md_operator_i  = 2'd1;
        if0.op_md_signed_i    = 2'd2;
        if0.op_is_mult_i      = m;
        if0.op_is_div_i       = d;
        if0.op_a_i            = a;
        if0.op_b_i            = b;
    endtask

    logic d1_mult_seen = 1'b0;
    logic mon_on = 1'b0;
    always @(posedge clk) if (mon_on && d1_mult_en) d1_mult_seen <= 1'b1;

    localparam logic [33:0] S0 = 34'h3_0000_0001;
    localparam logic [33:0] S1 = 34'h1_2345_6789;

    initial begin
        rst = 1'b1; kill = 1'b0; imd_we = '0; imd_d = '0;
        ex_valid = 1'b0; result_ex = '0; result_ready = 1'b0;
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(); step();
        chk("rst_ready", if0.instr_ready_o, 1);
        chk("rst_rvalid", res_vld, 0);
        chk("rst_result", res, 0);
        chk("rst_imd", imd_q, 0);
        chk("rst_opa", alu_a, 0);
        rst = 1'b0;

        // ALU ADD 5+7, ex_valid held high
        drive_op(1'b1, 6'd0, 1'b0, 1'b0, 32'd5, 32'd7);
        ex_valid = 1'b1; result_ex = 32'd12;
        step();                                   // T+1
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd5, 32'd7);
        chk("alu_first", first, 1);
        chk("alu_busy", if0.instr_ready_o, 0);
        chk("alu_opa", alu_a, 5);
        chk("alu_opb", alu_b, 7);
        chk("alu_mdopb", md_b, 7);
        chk("alu_mult_en", mult_en, 0);
        chk("alu_md_rdy", md_rdy, 1);
        chk("alu_rvalid_t1", res_vld, 0);
        step();                                   // T+2
        chk("alu_rvalid_t2", res_vld, 1);
        chk("alu_result", res, 12);
        chk("alu_first_off", first, 0);
        chk("alu_md_rdy_off", md_rdy, 0);
        result_ready = 1'b1; ex_valid = 1'b0;
        step();
        chk("alu_idle", if0.instr_ready_o, 1);
        chk("alu_rvalid_off", res_vld, 0);
        result_ready = 1'b0;

        // multi-cycle div, ex_valid in 4th EXEC cycle
        drive_op(1'b1, 6'd0, 1'b0, 1'b1, 32'd100, 32'd7);
        step();                                   // EXEC 1
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("div_en_%0d", k), div_en, 1);
            chk($sformatf("div_sel_%0d", k), div_sel, 1);
            chk($sformatf("div_mult_%0d", k), mult_en, 0);
            imd_we = 2'b00; imd_d = '0;
            case (k)
                1: begin imd_we = 2'b01; imd_d = {34'h0, S0}; end
                2: begin
                    chk("imd_slot0", imd_q[33:0], S0);
                    imd_we = 2'b10; imd_d = {S1, 34'h0_dead_beef};
                end
                3: begin
                    chk("imd_slot1", imd_q[67:34], S1);
                    chk("imd_slot0_keep", imd_q[33:0], S0);
                end
                default: begin ex_valid = 1'b1; result_ex = 32'd14; end
            endcase
            chk($sformatf("div_rvalid_%0d", k), res_vld, 0);
            step();
        end
        ex_valid = 1'b0; imd_we = '0;
        chk("div_rvalid_t5", res_vld, 1);
        chk("div_result", res, 14);
        chk("div_en_off", div_en, 0);
        chk("div_ill", ill, 0);

        // backpressure: ready low for 3 cycles
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_rvalid", res_vld, 1);
            chk("bp_result", res, 14);
            chk("bp_busy", if0.instr_ready_o, 0);
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("bp_idle", if0.instr_ready_o, 1);
        drive_op(1'b1, 6'd3, 1'b0, 1'b0, 32'd1, 32'd2);
        step();                                   // accepted the cycle after ready
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("bp_accept", first, 1);
        chk("bp_aluop", alu_op, 3);

        // kill in 2nd EXEC cycle with imd writes
        step();
        chk("kill_exec2", md_rdy, 1);
        kill = 1'b1; imd_we = 2'b11; imd_d = '1;
        step();
        kill = 1'b0; imd_we = '0; imd_d = '0;
        chk("kill_idle", if0.instr_ready_o, 1);
        chk("kill_rvalid", res_vld, 0);
        chk("kill_md_rdy", md_rdy, 0);
        chk("kill_imd", imd_q, {S1, S0});
        step();
        chk("kill_no_result", res_vld, 0);
        // kill also blocks a simultaneous accept
        drive_op(1'b1, 6'd4, 1'b0, 1'b0, 32'd8, 32'd8);
        kill = 1'b1;
        step();
        kill = 1'b0;
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("kill_noacc_rdy", if0.instr_ready_o, 1);
        chk("kill_noacc_first", first, 0);

        // reset during EXEC
        drive_op(1'b1, 6'd5, 1'b0, 1'b0, 32'd9, 32'd3);
        step();
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rx_opa", alu_a, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rx_ready", if0.instr_ready_o, 1);
        chk("rx_first", first, 0);
        chk("rx_opa0", alu_a, 0);
        chk("rx_aluop0", alu_op, 0);
        chk("rx_md_rdy", md_rdy, 0);
        chk("rx_imd", imd_q, 0);
        chk("rx_result", res, 0);
        chk("rx_rvalid", res_vld, 0);

        // mult request: RV32M=0 flags illegal, RV32M=2 executes
        mon_on = 1'b1;
        drive_op(1'b1, 6'd0, 1'b1, 1'b0, 32'd3, 32'd4);
        ex_valid = 1'b1; result_ex = 32'd55;
        step();                                   // T+1
        drive_op(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("nomd_rvalid", d1_res_vld, 1);
        chk("nomd_illegal", d1_ill, 1);
        chk("nomd_result", d1_res, 0);
        chk("nomd_md_rdy", d1_md_rdy, 0);
        chk("md_mult_en", mult_en, 1);
        chk("md_mult_sel", mult_sel, 1);
        result_ready = 1'b1;
        step();                                   // T+2
        ex_valid = 1'b0;
        chk("nomd_idle", if1.instr_ready_o, 1);
        chk("md_result", res, 55);
        chk("md_ill", ill, 0);
        step();
        result_ready = 1'b0;
        mon_on = 1'b0;
        chk("nomd_mult_never", d1_mult_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
